// File: rtl/cnt60_dn.sv
// cnt60_dn: MM:SS BCD countdown timer (max 59:59) with IDLE/RUN/PAUSE/DONE control.
// Optional held alarm output enabled by defining CNT60_DN_ALARM_EN; without it
// alarm is tied low and no alarm tick counter exists.
module cnt60_dn #(
    parameter int unsigned ALARM_TICKS = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ce,
    input  logic       load,
    input  logic [3:0] ld_lsbsec,
    input  logic [3:0] ld_msbsec,
    input  logic [3:0] ld_lsbmin,
    input  logic [3:0] ld_msbmin,
    input  logic       strtstop,
    output logic [3:0] lsbsec,
    output logic [3:0] msbsec,
    output logic [3:0] lsbmin,
    output logic [3:0] msbmin,
    output logic       running,
    output logic       zero,
    output logic       done,
    output logic       alarm
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // A zero-length alarm window is meaningless; reject it at elaboration.
    if (ALARM_TICKS == 0) begin : g_bad_alarm_ticks
        $error("cnt60_dn: ALARM_TICKS must be at least 1");
    end

    logic [1:0] r_state;
    logic [3:0] r_lsbsec, r_msbsec, r_lsbmin, r_msbmin;
    logic       r_done_pend;
    logic       r_done;

    logic [1:0] w_state_nxt;
    logic [3:0] w_lsbsec_nxt, w_msbsec_nxt, w_lsbmin_nxt, w_msbmin_nxt;
    logic [3:0] w_dec_lsbsec, w_dec_msbsec, w_dec_lsbmin, w_dec_msbmin;
    logic       w_dec_zero;
    logic       w_enter_done;
    logic       w_load_ok;

    assign w_load_ok = load && (r_state != S_RUN);

    // One-second decrement with BCD borrow chain; 00:00 never reaches here.
    always_comb begin
        w_dec_lsbsec = r_lsbsec;
        w_dec_msbsec = r_msbsec;
        w_dec_lsbmin = r_lsbmin;
        w_dec_msbmin = r_msbmin;
        if (r_lsbsec != 4'd0) begin
            w_dec_lsbsec = r_lsbsec - 4'd1;
        end else begin
            w_dec_lsbsec = 4'd9;
            if (r_msbsec != 4'd0) begin
                w_dec_msbsec = r_msbsec - 4'd1;
            end else begin
                w_dec_msbsec = 4'd5;
                if (r_lsbmin != 4'd0) begin
                    w_dec_lsbmin = r_lsbmin - 4'd1;
                end else begin
                    w_dec_lsbmin = 4'd9;
                    w_dec_msbmin = r_msbmin - 4'd1;
                end
            end
        end
        w_dec_zero = (w_dec_lsbsec == 4'd0) && (w_dec_msbsec == 4'd0) &&
                     (w_dec_lsbmin == 4'd0) && (w_dec_msbmin == 4'd0);
    end

    // Next-state and next-digit decode: load beats strtstop, ce only counts in RUN.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_lsbsec_nxt = r_lsbsec;
        w_msbsec_nxt = r_msbsec;
        w_lsbmin_nxt = r_lsbmin;
        w_msbmin_nxt = r_msbmin;
        w_enter_done = 1'b0;
        if (w_load_ok) begin
            w_lsbsec_nxt = (ld_lsbsec > 4'd9) ? 4'd9 : ld_lsbsec;
            w_msbsec_nxt = (ld_msbsec > 4'd5) ? 4'd5 : ld_msbsec;
            w_lsbmin_nxt = (ld_lsbmin > 4'd9) ? 4'd9 : ld_lsbmin;
            w_msbmin_nxt = (ld_msbmin > 4'd5) ? 4'd5 : ld_msbmin;
            w_state_nxt  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (strtstop && !zero) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (strtstop) w_state_nxt = S_PAUSE;
                    if (ce && !zero) begin
                        w_lsbsec_nxt = w_dec_lsbsec;
                        w_msbsec_nxt = w_dec_msbsec;
                        w_lsbmin_nxt = w_dec_lsbmin;
                        w_msbmin_nxt = w_dec_msbmin;
                        // Reaching 00:00 ends the run even if strtstop arrived too.
                        if (w_dec_zero) begin
                            w_state_nxt  = S_DONE;
                            w_enter_done = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (strtstop) w_state_nxt = S_RUN;
                end
                default: begin
                    if (strtstop) w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, digit and done-pulse registers with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (clr) begin
            r_state     <= S_IDLE;
            r_lsbsec    <= 4'd0;
            r_msbsec    <= 4'd0;
            r_lsbmin    <= 4'd0;
            r_msbmin    <= 4'd0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lsbsec    <= w_lsbsec_nxt;
            r_msbsec    <= w_msbsec_nxt;
            r_lsbmin    <= w_lsbmin_nxt;
            r_msbmin    <= w_msbmin_nxt;
            r_done_pend <= w_enter_done;
            r_done      <= r_done_pend;
        end
    end

`ifdef CNT60_DN_ALARM_EN
    localparam int unsigned ALARM_CW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

    logic                r_alarm;
    logic [ALARM_CW-1:0] r_alarm_cnt;

    // Alarm rises on entry to DONE, falls after ALARM_TICKS ce ticks or on leaving DONE.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else if (w_enter_done) begin
            r_alarm     <= 1'b1;
            r_alarm_cnt <= '0;
        end else if (r_alarm) begin
            if (w_state_nxt != S_DONE) begin
                r_alarm <= 1'b0;
            end else if (ce) begin
                if (r_alarm_cnt == ALARM_CW'(ALARM_TICKS - 1)) begin
                    r_alarm <= 1'b0;
                end else begin
                    r_alarm_cnt <= r_alarm_cnt + 1'b1;
                end
            end
        end
    end

    assign alarm = r_alarm;
`else
    assign alarm = 1'b0;
`endif

    assign lsbsec  = r_lsbsec;
    assign msbsec  = r_msbsec;
    assign lsbmin  = r_lsbmin;
    assign msbmin  = r_msbmin;
    assign done    = r_done;
    assign running = (r_state == S_RUN);
    assign zero    = (r_lsbsec == 4'd0) && (r_msbsec == 4'd0) &&
                     (r_lsbmin == 4'd0) && (r_msbmin == 4'd0);

endmodule

// File: tb/tb_cnt60_dn.sv
// Directed bench for cnt60_dn; count is viewed as 16-bit BCD {msbmin,lsbmin,msbsec,lsbsec}.
module tb_cnt60_dn;

    logic       clk = 1'b0;
    logic       clr, ce, load, strtstop;
    logic [3:0] ld_lsbsec, ld_msbsec, ld_lsbmin, ld_msbmin;
    logic [3:0] lsbsec, msbsec, lsbmin, msbmin;
    logic       running, zero, done, alarm;
    logic [15:0] w_cnt;

    int errors = 0;
    int checks = 0;

    cnt60_dn #(.ALARM_TICKS(8)) dut (
        .clk(clk), .clr(clr), .ce(ce), .load(load),
        .ld_lsbsec(ld_lsbsec), .ld_msbsec(ld_msbsec),
        .ld_lsbmin(ld_lsbmin), .ld_msbmin(ld_msbmin),
        .strtstop(strtstop),
        .lsbsec(lsbsec), .msbsec(msbsec), .lsbmin(lsbmin), .msbmin(msbmin),
        .running(running), .zero(zero), .done(done), .alarm(alarm)
    );

    assign w_cnt = {msbmin, lsbmin, msbsec, lsbsec};

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // One clock with the given strobes; outputs are stable 1 ns after the edge.
    task automatic cyc(input logic i_ce, input logic i_ss, input logic i_ld, input logic i_clr);
        ce = i_ce; strtstop = i_ss; load = i_ld; clr = i_clr;
        @(posedge clk);
        #1;
        ce = 1'b0; strtstop = 1'b0; load = 1'b0; clr = 1'b0;
    endtask

    task automatic set_ld(input logic [15:0] v);
        {ld_msbmin, ld_lsbmin, ld_msbsec, ld_lsbsec} = v;
    endtask

    task automatic test_reset;
        set_ld(16'h1234);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (w_cnt !== 16'h0000) begin errors++; $display("FAIL rst_cnt: got %h want 0000", w_cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b want 0", running); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %b want 1", zero); end
        checks++; if (done !== 1'b0 || alarm !== 1'b0) begin errors++; $display("FAIL rst_done_alarm: got %b%b want 00", done, alarm); end
    endtask

    task automatic test_countdown;
        int done_seen = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_ld(16'h0100);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (w_cnt !== 16'h0100) begin errors++; $display("FAIL cd_load: got %h want 0100", w_cnt); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0100) begin errors++; $display("FAIL cd_idle_ce: got %h want 0100", w_cnt); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL cd_start: running %b want 1", running); end
        for (int s = 59; s >= 0; s--) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (done === 1'b1) done_seen++;
            checks++; if (w_cnt !== to_bcd(s)) begin errors++; $display("FAIL cd_step: got %h want %h", w_cnt, to_bcd(s)); end
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL cd_early_done: got %0d pulses want 0", done_seen); end
        checks++; if (running !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL cd_end: running/zero %b%b want 01", running, zero); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cd_done_pulse: got %b want 1", done); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cd_done_width: got %b want 0", done); end
        checks++; if (w_cnt !== 16'h0000) begin errors++; $display("FAIL cd_done_hold: got %h want 0000", w_cnt); end
`ifndef CNT60_DN_ALARM_EN
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL cd_no_alarm: got %b want 0", alarm); end
`endif
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cd_zero_start: running/done %b%b want 00", running, done); end
    endtask

    task automatic test_clamp_borrow;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        {ld_msbmin, ld_lsbmin, ld_msbsec, ld_lsbsec} = {4'h9, 4'hA, 4'h7, 4'hC};
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (w_cnt !== 16'h5959) begin errors++; $display("FAIL clamp: got %h want 5959", w_cnt); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h5958) begin errors++; $display("FAIL max_dec: got %h want 5958", w_cnt); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        set_ld(16'h1000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (w_cnt !== 16'h1000 || running !== 1'b0) begin errors++; $display("FAIL pause_load: got %h/%b want 1000/0", w_cnt, running); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0959) begin errors++; $display("FAIL borrow: got %h want 0959", w_cnt); end
        set_ld(16'h0005);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (w_cnt !== 16'h0959 || running !== 1'b1) begin errors++; $display("FAIL run_load_ignored: got %h/%b want 0959/1", w_cnt, running); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0958) begin errors++; $display("FAIL dec_after: got %h want 0958", w_cnt); end
    endtask

    task automatic test_pause;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_ld(16'h0005);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0003) begin errors++; $display("FAIL pz_run: got %h want 0003", w_cnt); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0002 || running !== 1'b0) begin errors++; $display("FAIL pz_ce_stop: got %h/%b want 0002/0", w_cnt, running); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0002) begin errors++; $display("FAIL pz_hold: got %h want 0002", w_cnt); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL pz_resume: running %b want 1", running); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0001) begin errors++; $display("FAIL pz_resume_dec: got %h want 0001", w_cnt); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        set_ld(16'h0030);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (w_cnt !== 16'h0030 || running !== 1'b0) begin errors++; $display("FAIL pz_load_wins: got %h/%b want 0030/0", w_cnt, running); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0030) begin errors++; $display("FAIL pz_idle_ce: got %h want 0030", w_cnt); end
    endtask

    task automatic test_zero_load;
        int done_seen = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_ld(16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL zl_state: running/zero %b%b want 01", running, zero); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (done === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0 || w_cnt !== 16'h0000) begin errors++; $display("FAIL zl_no_done: pulses %0d cnt %h want 0/0000", done_seen, w_cnt); end
    endtask

`ifdef CNT60_DN_ALARM_EN
    task automatic test_alarm;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_ld(16'h0002);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL al_early: got %b want 0", alarm); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL al_rise: got %b want 1", alarm); end
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            checks++; if (alarm !== (k < 8)) begin errors++; $display("FAIL al_tick%0d: got %b want %b", k, alarm, (k < 8)); end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        set_ld(16'h0001);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL al_rise2: got %b want 1", alarm); end
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL al_hold3: got %b want 1", alarm); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL al_ack: alarm/running %b%b want 00", alarm, running); end
    endtask
`endif

    task automatic test_clr_midrun;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_ld(16'h0031);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (w_cnt !== 16'h0030) begin errors++; $display("FAIL cm_pre: got %h want 0030", w_cnt); end
        set_ld(16'h0545);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (w_cnt !== 16'h0000 || running !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL cm_clr: cnt %h run %b zero %b want 0000/0/1", w_cnt, running, zero); end
        checks++; if (done !== 1'b0 || alarm !== 1'b0) begin errors++; $display("FAIL cm_flags: done/alarm %b%b want 00", done, alarm); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cm_no_done: got %b want 0", done); end
    endtask

    initial begin
        clr = 1'b1; ce = 1'b0; load = 1'b0; strtstop = 1'b0;
        set_ld(16'h0000);
        test_reset;
        test_countdown;
        test_clamp_borrow;
        test_pause;
        test_zero_load;
`ifdef CNT60_DN_ALARM_EN
        test_alarm;
`endif
        test_clr_midrun;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
